branch_counter_table: RTL and testbench
=======================================

BRANCH_COUNTER_TABLE -- requirements
Module: branch_counter_table

Interface
REQ-001 Parameter INIT_STATE, default 2'b01, is the counter value loaded on reset and on clear (weakly not-taken).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous re-initialisation of all 16 counters.
REQ-005 upd_valid  input  1  branch-resolution update strobe.
REQ-006 upd_index  input  4  counter index to update.
REQ-007 upd_taken  input  1  resolved direction: 1 taken, 0 not-taken.
REQ-008 pred_valid  input  1  lookup request strobe.
REQ-009 pred_index  input  4  counter index to look up.
REQ-010 counter0..counter15  output  2 each  architectural counter values; these drive the 16-to-1 2-bit select mux downstream.
REQ-011 pred_out_valid  output  1  registered lookup-result strobe.
REQ-012 pred_taken  output  1  registered prediction (MSB of the effective counter).
REQ-013 pred_counter  output  2  registered effective counter value.

Function
REQ-014 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 Update is two-stage: edge E1 captures {upd_valid, upd_index, upd_taken} into a staging register; edge E2 writes the selected counter.
REQ-016 Taken increments, saturating at 11; not-taken decrements, saturating at 00; other counters hold.
REQ-017 upd_valid=0 at E1 stages nothing; E2 changes no counter.
REQ-018 Back-to-back updates to one index accumulate: each applied update uses the array value that already includes every earlier update.
REQ-019 Lookup latency is 1 cycle: pred_valid sampled at edge E drives pred_out_valid=1 and pred_taken/pred_counter after E; pred_out_valid=0 otherwise.
REQ-020 Effective counter for lookup = array value with any valid staged update to the same index applied (forwarding); otherwise the raw array value.
REQ-021 When pred_out_valid=0, pred_taken and pred_counter hold their previous values.
REQ-022 counterN outputs reflect the array only; they never show forwarded values.
REQ-023 clear=1 at an edge sets all counters to INIT_STATE, discards the staged update, and blocks staging of a same-cycle upd_valid.
REQ-024 A lookup during clear returns the pre-clear effective value; the following lookup sees INIT_STATE.

Reset
REQ-025 rst=1 immediately forces all counters to INIT_STATE, staging valid=0, pred_out_valid=0, pred_taken=0, pred_counter=INIT_STATE, independent of clk.
REQ-026 Reset asserted mid-update discards the staged update; no counter changes on the first edge after rst deasserts unless a new update has been staged.

Structure
REQ-027 Counter state constants (SNT, WNT, WT, ST) and the counter width belong in the shared predictor package.
REQ-028 The saturating next-state function is one sub-module, sat_counter_2bit, shared by the array write path and the forwarding path.

Verification
REQ-029 Reset, then read all outputs -> counter0..15=01, pred_out_valid=0.
REQ-030 Three taken updates to index 5 on consecutive cycles -> counter5 goes 01,10,11,11, becoming valid two cycles after each strobe; other counters stay 01.
REQ-031 Four not-taken updates to index 0 -> counter0 saturates at 00 and stays.
REQ-032 Taken update to index 9, then pred_valid on index 9 one cycle later -> pred_counter=10, pred_taken=1 via forwarding, while counter9 still reads 01.
REQ-033 clear asserted with a staged taken update to index 3 -> counter3=01 afterward; no later increment.
REQ-034 rst asserted between staging and apply of an update to index 7 -> counter7=01; pred_out_valid=0.

Source files
------------

// File: rtl/branch_counter_table_pkg.sv
// Shared predictor definitions: counter width, table geometry and 2-bit counter states.
package branch_counter_table_pkg;

   localparam int unsigned CTR_W   = 2;
   localparam int unsigned NUM_CTR = 16;
   localparam int unsigned IDX_W   = 4;

   // Saturating 2-bit counter states
   localparam logic [CTR_W-1:0] SNT = CTR_W'(0);  // strongly not-taken
   localparam logic [CTR_W-1:0] WNT = CTR_W'(1);  // weakly not-taken
   localparam logic [CTR_W-1:0] WT  = CTR_W'(2);  // weakly taken
   localparam logic [CTR_W-1:0] ST  = CTR_W'(3);  // strongly taken

endpackage

// File: rtl/branch_counter_table_if.sv
// Update and lookup bus between the predictor front end and the counter table.
interface branch_counter_table_if;
   import branch_counter_table_pkg::*;

   logic             upd_valid;
   logic [IDX_W-1:0] upd_index;
   logic             upd_taken;
   logic             pred_valid;
   logic [IDX_W-1:0] pred_index;
   logic             pred_out_valid;
   logic             pred_taken;
   logic [CTR_W-1:0] pred_counter;

   modport master (
      output upd_valid, upd_index, upd_taken, pred_valid, pred_index,
      input  pred_out_valid, pred_taken, pred_counter
   );

   modport slave (
      input  upd_valid, upd_index, upd_taken, pred_valid, pred_index,
      output pred_out_valid, pred_taken, pred_counter
   );

endinterface

// File: rtl/branch_counter_table_sat_counter_2bit.sv
// Saturating 2-bit counter next-state: taken counts up to ST, not-taken down to SNT.
module sat_counter_2bit
   import branch_counter_table_pkg::*;
(
   input  logic [CTR_W-1:0] cur_i,
   input  logic             taken_i,
   output logic [CTR_W-1:0] next_c
);

   // Step toward the resolved direction, holding at either end
   always_comb begin
      next_c = cur_i;
      if (taken_i) begin
         if (cur_i != ST) next_c = cur_i + CTR_W'(1);
      end else begin
         if (cur_i != SNT) next_c = cur_i - CTR_W'(1);
      end
   end

endmodule

// File: rtl/branch_counter_table.sv
// 16-entry table of 2-bit branch counters with staged updates and forwarded lookups.
module branch_counter_table
   import branch_counter_table_pkg::*;
#(
   parameter logic [CTR_W-1:0] INIT_STATE = WNT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   branch_counter_table_if.slave   bus,
   output logic [CTR_W-1:0]        counter0,
   output logic [CTR_W-1:0]        counter1,
   output logic [CTR_W-1:0]        counter2,
   output logic [CTR_W-1:0]        counter3,
   output logic [CTR_W-1:0]        counter4,
   output logic [CTR_W-1:0]        counter5,
   output logic [CTR_W-1:0]        counter6,
   output logic [CTR_W-1:0]        counter7,
   output logic [CTR_W-1:0]        counter8,
   output logic [CTR_W-1:0]        counter9,
   output logic [CTR_W-1:0]        counter10,
   output logic [CTR_W-1:0]        counter11,
   output logic [CTR_W-1:0]        counter12,
   output logic [CTR_W-1:0]        counter13,
   output logic [CTR_W-1:0]        counter14,
   output logic [CTR_W-1:0]        counter15
);

   logic [CTR_W-1:0] cnt_q [NUM_CTR];
   logic [CTR_W-1:0] cnt_d [NUM_CTR];

   logic             stage_valid_q, stage_valid_d;
   logic [IDX_W-1:0] stage_index_q, stage_index_d;
   logic             stage_taken_q, stage_taken_d;

   logic             pred_out_valid_q, pred_out_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic [CTR_W-1:0] pred_counter_q, pred_counter_d;

   logic [CTR_W-1:0] wr_cur_c, wr_next_c;
   logic [CTR_W-1:0] fwd_cur_c, fwd_next_c;
   logic             fwd_hit_c;

   assign wr_cur_c  = cnt_q[stage_index_q];
   assign fwd_cur_c = cnt_q[bus.pred_index];
   assign fwd_hit_c = stage_valid_q && (stage_index_q == bus.pred_index);

   sat_counter_2bit u_sat_wr (
      .cur_i   (wr_cur_c),
      .taken_i (stage_taken_q),
      .next_c  (wr_next_c)
   );

   // Same next-state applied ahead of time so a lookup sees the in-flight update
   sat_counter_2bit u_sat_fwd (
      .cur_i   (fwd_cur_c),
      .taken_i (stage_taken_q),
      .next_c  (fwd_next_c)
   );

   // Stage the incoming update; clear suppresses a same-cycle strobe
   always_comb begin
      stage_valid_d = bus.upd_valid & ~clear;
      stage_index_d = bus.upd_index;
      stage_taken_d = bus.upd_taken;
   end

   // Array write: clear wins over the staged update
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '{default: INIT_STATE};
      end else if (stage_valid_q) begin
         cnt_d[stage_index_q] = wr_next_c;
      end
   end

   // Lookup result: forwarded effective counter on request, otherwise hold
   always_comb begin
      pred_out_valid_d = bus.pred_valid;
      pred_counter_d   = pred_counter_q;
      pred_taken_d     = pred_taken_q;
      if (bus.pred_valid) begin
         pred_counter_d = fwd_hit_c ? fwd_next_c : fwd_cur_c;
         pred_taken_d   = pred_counter_d[CTR_W-1];
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q            <= '{default: INIT_STATE};
         stage_valid_q    <= 1'b0;
         stage_index_q    <= '0;
         stage_taken_q    <= 1'b0;
         pred_out_valid_q <= 1'b0;
         pred_taken_q     <= 1'b0;
         pred_counter_q   <= INIT_STATE;
      end else begin
         cnt_q            <= cnt_d;
         stage_valid_q    <= stage_valid_d;
         stage_index_q    <= stage_index_d;
         stage_taken_q    <= stage_taken_d;
         pred_out_valid_q <= pred_out_valid_d;
         pred_taken_q     <= pred_taken_d;
         pred_counter_q   <= pred_counter_d;
      end
   end

   assign bus.pred_out_valid = pred_out_valid_q;
   assign bus.pred_taken     = pred_taken_q;
   assign bus.pred_counter   = pred_counter_q;

   assign counter0  = cnt_q[0];
   assign counter1  = cnt_q[1];
   assign counter2  = cnt_q[2];
   assign counter3  = cnt_q[3];
   assign counter4  = cnt_q[4];
   assign counter5  = cnt_q[5];
   assign counter6  = cnt_q[6];
   assign counter7  = cnt_q[7];
   assign counter8  = cnt_q[8];
   assign counter9  = cnt_q[9];
   assign counter10 = cnt_q[10];
   assign counter11 = cnt_q[11];
   assign counter12 = cnt_q[12];
   assign counter13 = cnt_q[13];
   assign counter14 = cnt_q[14];
   assign counter15 = cnt_q[15];

endmodule

// File: tb/tb_branch_counter_table.sv
// Scoreboard bench for branch_counter_table: directed scenarios plus random traffic.
module tb_branch_counter_table;

   localparam int INIT = 1;

   logic       clk;
   logic       rst;
   logic       clear;
   logic [1:0] dut_ctr [16];

   branch_counter_table_if bus ();

   branch_counter_table #(.INIT_STATE(2'b01)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .bus       (bus),
      .counter0  (dut_ctr[0]),
      .counter1  (dut_ctr[1]),
      .counter2  (dut_ctr[2]),
      .counter3  (dut_ctr[3]),
      .counter4  (dut_ctr[4]),
      .counter5  (dut_ctr[5]),
      .counter6  (dut_ctr[6]),
      .counter7  (dut_ctr[7]),
      .counter8  (dut_ctr[8]),
      .counter9  (dut_ctr[9]),
      .counter10 (dut_ctr[10]),
      .counter11 (dut_ctr[11]),
      .counter12 (dut_ctr[12]),
      .counter13 (dut_ctr[13]),
      .counter14 (dut_ctr[14]),
      .counter15 (dut_ctr[15])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: counters as plain integers plus the one in-flight update
   int ref_ctr [16];
   bit pend_v;
   int pend_i;
   bit pend_t;
   int exp_q[$];
   int last_pred;
   int n_cmp;
   int n_fail;

   function automatic int sat(input int c, input bit t);
      if (t) return (c + 1 > 3) ? 3 : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_counters();
      for (int i = 0; i < 16; i++)
         chk($sformatf("counter%0d", i), int'(dut_ctr[i]), ref_ctr[i]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ref_ctr[i] = INIT;
      pend_v = 1'b0;
      pend_i = 0;
      pend_t = 1'b0;
      exp_q.delete();
      last_pred = INIT;
   endtask

   // One clock of stimulus; model advances to the state after the coming edge
   task automatic step(input bit uv, input int ui, input bit ut,
                       input bit pv, input int pi, input bit clr);
      int e;
      @(negedge clk);
      check_counters();
      bus.upd_valid  = uv;
      bus.upd_index  = 4'(ui);
      bus.upd_taken  = ut;
      bus.pred_valid = pv;
      bus.pred_index = 4'(pi);
      clear          = clr;
      if (pv) begin
         e = ref_ctr[pi];
         if (pend_v && pend_i == pi) e = sat(e, pend_t);
         exp_q.push_back(e);
      end
      if (clr) begin
         for (int i = 0; i < 16; i++) ref_ctr[i] = INIT;
      end else if (pend_v) begin
         ref_ctr[pend_i] = sat(ref_ctr[pend_i], pend_t);
      end
      pend_v = uv && !clr;
      pend_i = ui;
      pend_t = ut;
   endtask

   // Asynchronous reset pulse asserted mid-cycle, away from any edge
   task automatic do_reset();
      @(negedge clk);
      check_counters();
      #2;
      rst            = 1'b1;
      bus.upd_valid  = 1'b0;
      bus.pred_valid = 1'b0;
      clear          = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 16; i++)
         chk($sformatf("rst_counter%0d", i), int'(dut_ctr[i]), INIT);
      chk("rst_pred_out_valid", int'(bus.pred_out_valid), 0);
      chk("rst_pred_taken", int'(bus.pred_taken), 0);
      chk("rst_pred_counter", int'(bus.pred_counter), INIT);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic monitor();
      int e;
      forever begin
         @(negedge clk);
         if (bus.pred_out_valid) begin
            if (exp_q.size() == 0) begin
               chk("pred_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pred_counter", int'(bus.pred_counter), e);
               chk("pred_taken", int'(bus.pred_taken), (e >= 2) ? 1 : 0);
               last_pred = e;
            end
         end else begin
            chk("pred_hold_counter", int'(bus.pred_counter), last_pred);
            chk("pred_hold_taken", int'(bus.pred_taken), (last_pred >= 2) ? 1 : 0);
         end
      end
   endtask

   initial begin
      int ui;
      int pi;
      n_cmp          = 0;
      n_fail         = 0;
      rst            = 1'b1;
      clear          = 1'b0;
      bus.upd_valid  = 1'b0;
      bus.upd_index  = '0;
      bus.upd_taken  = 1'b0;
      bus.pred_valid = 1'b0;
      bus.pred_index = '0;
      model_reset();
      do_reset();
      fork
         monitor();
      join_none

      // Three taken updates to index 5, then idle while they drain
      for (int k = 0; k < 3; k++) step(1, 5, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);

      // Four not-taken updates to index 0 saturate at strong not-taken
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0);

      // Lookup one cycle after a taken update must see the forwarded value
      step(1, 9, 1, 0, 0, 0);
      step(0, 0, 0, 1, 9, 0);
      step(0, 0, 0, 1, 9, 0);

      // Clear with a staged update; lookup during clear sees pre-clear value
      step(1, 3, 1, 0, 0, 0);
      step(1, 3, 1, 1, 3, 1);
      step(0, 0, 0, 1, 3, 0);
      for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 3, 0);

      // Reset between staging and apply of an update to index 7
      step(1, 7, 1, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 1, 7, 0);
      step(0, 0, 0, 0, 0, 0);

      // Random traffic concentrated on a few indices to exercise collisions
      for (int k = 0; k < 500; k++) begin
         ui = ($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         pi = ($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         step($urandom % 3 != 0, ui, $urandom % 2 == 1,
              $urandom % 2 == 1, pi, $urandom % 25 == 0);
         if (k % 150 == 149) do_reset();
      end

      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("queue_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
